// File: rtl/mul_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : mul_spi_master
// Purpose  : SPI master that offloads a multiply to a remote slave. It sends
//            a start bit, then the packet {op_2, op_1} LSB first. It waits for
//            a one-cycle ack (miso=1) and then shifts in the R-bit product,
//            LSB first.
// Ports    : i_clock, i_reset    - clock, synchronous active-high reset
//            i_start             - request a transaction (accepted in IDLE)
//            i_slave             - target slave index (nss bit)
//            i_op_1, i_op_2      - operands (packet low / high half)
//            o_busy              - high whenever not IDLE
//            o_done              - one-cycle pulse, o_result valid
//            o_error             - one-cycle pulse, bad index or ack timeout
//            o_result            - received product, held between starts
//            o_spi_nss           - per-slave select, active low
//            o_spi_mosi          - serial data to the slave
//            i_spi_miso          - serial data from the slave
// Revision : 1.0 - initial release
// ============================================================================
module mul_spi_master #(
   parameter int  REGISTER_SIZE = 8,
   parameter int  NUM_SLAVES    = 1,
   parameter int  ACK_TIMEOUT   = 16,
   localparam int c_slave_w     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic [c_slave_w-1:0]     i_slave,
   input  logic [REGISTER_SIZE-1:0] i_op_1,
   input  logic [REGISTER_SIZE-1:0] i_op_2,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_error,
   output logic [REGISTER_SIZE-1:0] o_result,
   output logic [NUM_SLAVES-1:0]    o_spi_nss,
   output logic                     o_spi_mosi,
   input  logic                     i_spi_miso
);

   // The shared counter must reach both the last SEND bit and the last
   // WAIT_ACK cycle.
   localparam int c_cnt_max = (2*REGISTER_SIZE > ACK_TIMEOUT) ? 2*REGISTER_SIZE : ACK_TIMEOUT;
   localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

   localparam logic [c_cnt_w-1:0]         c_send_last = c_cnt_w'(2*REGISTER_SIZE - 1);
   localparam logic [c_cnt_w-1:0]         c_recv_last = c_cnt_w'(REGISTER_SIZE - 1);
   localparam logic [c_cnt_w-1:0]         c_ack_last  = c_cnt_w'(ACK_TIMEOUT - 1);
   localparam logic [2*REGISTER_SIZE-1:0] c_one_pkt   = (2*REGISTER_SIZE)'(1);
   localparam logic [REGISTER_SIZE-1:0]   c_one_res   = REGISTER_SIZE'(1);
   localparam logic [NUM_SLAVES-1:0]      c_one_sel   = NUM_SLAVES'(1);

   localparam logic [2:0] c_st_idle     = 3'd0;
   localparam logic [2:0] c_st_start    = 3'd1;
   localparam logic [2:0] c_st_send     = 3'd2;
   localparam logic [2:0] c_st_wait_ack = 3'd3;
   localparam logic [2:0] c_st_recv     = 3'd4;
   localparam logic [2:0] c_st_done     = 3'd5;

   logic [2:0]                 r_state;
   logic [2:0]                 w_next_state;
   logic [c_cnt_w-1:0]         r_count;
   logic [2*REGISTER_SIZE-1:0] r_packet;
   logic [c_slave_w-1:0]       r_idx;
   logic [REGISTER_SIZE-1:0]   r_result;
   logic                       r_error;

   logic                       w_slave_ok;
   logic                       w_accept;
   logic                       w_reject;
   logic                       w_timeout;
   logic                       w_counting;
   logic [REGISTER_SIZE-1:0]   w_bit_mask;
   logic [NUM_SLAVES-1:0]      w_sel_n;

   assign w_slave_ok = 32'(i_slave) < 32'(NUM_SLAVES);
   assign w_accept   = (r_state == c_st_idle) && i_start && w_slave_ok;
   assign w_reject   = (r_state == c_st_idle) && i_start && !w_slave_ok;
   // miso wins over the timeout on the last allowed wait cycle.
   assign w_timeout  = (r_state == c_st_wait_ack) && !i_spi_miso && (r_count == c_ack_last);
   assign w_counting = (r_state == c_st_send) || (r_state == c_st_wait_ack) ||
                       (r_state == c_st_recv);
   assign w_bit_mask = c_one_res << r_count;
   assign w_sel_n    = ~(c_one_sel << r_idx);

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle:     if (w_accept) w_next_state = c_st_start;
         c_st_start:    w_next_state = c_st_send;
         c_st_send:     if (r_count == c_send_last) w_next_state = c_st_wait_ack;
         c_st_wait_ack: begin
            if (i_spi_miso)     w_next_state = c_st_recv;
            else if (w_timeout) w_next_state = c_st_idle;
         end
         c_st_recv:     if (r_count == c_recv_last) w_next_state = c_st_done;
         c_st_done:     w_next_state = c_st_idle;
         default:       w_next_state = c_st_idle;
      endcase
   end

   // Datapath: shared bit counter, latched request, result capture, error pulse
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count  <= '0;
         r_packet <= '0;
         r_idx    <= '0;
         r_result <= '0;
         r_error  <= 1'b0;
      end else begin
         r_error <= w_reject || w_timeout;
         // Cleared on every state entry so each state counts from zero.
         if (r_state != w_next_state) begin
            r_count <= '0;
         end else if (w_counting) begin
            r_count <= r_count + 1'b1;
         end
         if (w_accept) begin
            r_packet <= {i_op_2, i_op_1};
            r_idx    <= i_slave;
         end
         if (r_state == c_st_recv) begin
            r_result <= (r_result & ~w_bit_mask) | (i_spi_miso ? w_bit_mask : '0);
         end
      end
   end

   // Output logic
   always_comb begin
      o_busy     = (r_state != c_st_idle);
      o_done     = (r_state == c_st_done);
      o_error    = r_error;
      o_result   = r_result;
      o_spi_nss  = '1;
      o_spi_mosi = 1'b0;
      case (r_state)
         c_st_start: begin
            o_spi_nss  = w_sel_n;
            o_spi_mosi = 1'b1;
         end
         c_st_send: begin
            o_spi_nss  = w_sel_n;
            o_spi_mosi = |(r_packet & (c_one_pkt << r_count));
         end
         c_st_wait_ack, c_st_recv: begin
            o_spi_nss  = w_sel_n;
         end
         default: begin
            o_spi_nss  = '1;
            o_spi_mosi = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_spi_master
// Purpose  : Self-checking bench for mul_spi_master (R=8, three slaves,
//            ack timeout 16). A behavioural multiplier slave answers on the
//            bus. A cycle-indexed timeline model gives the expected outputs
//            for every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_spi_master;

   localparam int R    = 8;
   localparam int NS   = 3;
   localparam int TO   = 16;
   localparam int MAXC = 4096;

   logic       clk = 1'b0;
   logic       r_rst, r_start, r_miso;
   logic [1:0] r_slave;
   logic [7:0] r_op1, r_op2;
   logic       w_busy, w_done, w_err, w_mosi;
   logic [7:0] w_result;
   logic [2:0] w_nss;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;
   int chk_from = 0;

   // Slave behaviour controls, set by the driver per transaction.
   bit ack_en    = 1'b1;
   int ack_delay = 1;

   // Expected timeline, one entry per cycle.
   logic       exp_busy [MAXC];
   logic [2:0] exp_nss  [MAXC];
   logic       exp_mosi [MAXC];
   logic       exp_done [MAXC];
   logic       exp_err  [MAXC];
   logic [7:0] exp_res  [MAXC];
   logic       res_chk  [MAXC];
   logic [7:0] m_res;

   mul_spi_master #(
      .REGISTER_SIZE (R),
      .NUM_SLAVES    (NS),
      .ACK_TIMEOUT   (TO)
   ) dut (
      .i_clock    (clk),
      .i_reset    (r_rst),
      .i_start    (r_start),
      .i_slave    (r_slave),
      .i_op_1     (r_op1),
      .i_op_2     (r_op2),
      .o_busy     (w_busy),
      .o_done     (w_done),
      .o_error    (w_err),
      .o_result   (w_result),
      .o_spi_nss  (w_nss),
      .o_spi_mosi (w_mosi),
      .i_spi_miso (r_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endfunction

   // ---------------- timeline model ----------------
   function automatic void fill_idle(int from);
      for (int c = from; c < MAXC; c++) begin
         exp_busy[c] = 1'b0; exp_nss[c] = 3'b111; exp_mosi[c] = 1'b0;
         exp_done[c] = 1'b0; exp_err[c] = 1'b0;
         exp_res[c]  = m_res; res_chk[c] = 1'b1;
      end
   endfunction

   function automatic void set_active(int c, int idx, logic m);
      if (c < MAXC) begin
         exp_busy[c] = 1'b1;
         exp_nss[c]  = ~(3'b001 << idx);
         exp_mosi[c] = m;
      end
   endfunction

   function automatic void model_reset(int c);
      m_res = 8'h00;
      fill_idle(c + 1);
   endfunction

   // Start in cycle t0; returns the first cycle in which a new start is accepted.
   function automatic int model_start(int t0, int idx, logic [7:0] a, logic [7:0] b,
                                      bit ack, int d);
      logic [15:0] pkt;
      int w, fin;
      if (idx >= NS) begin
         exp_err[t0+1] = 1'b1;
         return t0 + 1;
      end
      pkt = {b, a};
      set_active(t0 + 1, idx, 1'b1);
      for (int k = 0; k < 2*R; k++) set_active(t0 + 2 + k, idx, pkt[k]);
      w = t0 + 2 + 2*R;
      if (!ack || d >= TO) begin
         for (int j = 0; j < TO; j++) set_active(w + j, idx, 1'b0);
         exp_err[w+TO] = 1'b1;
         return w + TO;
      end
      for (int j = 0; j <= d; j++) set_active(w + j, idx, 1'b0);
      for (int k = 0; k < R; k++) begin
         set_active(w + d + 1 + k, idx, 1'b0);
         res_chk[w+d+1+k] = 1'b0;
      end
      fin   = w + d + 1 + R;
      m_res = a * b;
      fill_idle(fin);
      exp_busy[fin] = 1'b1;
      exp_done[fin] = 1'b1;
      return fin + 1;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on && cyc >= chk_from && cyc < MAXC) begin
         chk("busy",  32'(w_busy), 32'(exp_busy[cyc]));
         chk("nss",   32'(w_nss),  32'(exp_nss[cyc]));
         chk("mosi",  32'(w_mosi), 32'(exp_mosi[cyc]));
         chk("done",  32'(w_done), 32'(exp_done[cyc]));
         chk("error", 32'(w_err),  32'(exp_err[cyc]));
         if (res_chk[cyc]) chk("result", 32'(w_result), 32'(exp_res[cyc]));
      end
   end

   // ---------------- multiplier slave ----------------
   initial begin
      int sl_state, sl_bits, sl_wait;
      logic [15:0] sl_pkt;
      logic [7:0]  sl_prod;
      sl_state = 0; sl_bits = 0; sl_wait = 0; sl_pkt = '0; sl_prod = '0;
      r_miso = 1'b0;
      forever begin
         @(negedge clk);
         if (sl_state != 0 && w_nss == 3'b111) sl_state = 0;
         case (sl_state)
            0: begin
               r_miso = 1'($urandom);      // noise while deselected
               if (w_nss != 3'b111 && w_mosi) begin
                  sl_state = 1; sl_bits = 0; sl_pkt = '0;
               end
            end
            1: begin
               r_miso = 1'($urandom);
               sl_pkt[sl_bits] = w_mosi;
               sl_bits++;
               if (sl_bits == 16) begin sl_state = 2; sl_wait = 0; end
            end
            2: begin
               if (ack_en && sl_wait == ack_delay) begin
                  r_miso = 1'b1; sl_state = 3; sl_bits = 0;
                  sl_prod = sl_pkt[7:0] * sl_pkt[15:8];
               end else begin
                  r_miso = 1'b0;
               end
               sl_wait++;
            end
            default: begin
               r_miso = sl_prod[sl_bits];
               sl_bits++;
               if (sl_bits == 8) sl_state = 0;
            end
         endcase
      end
   end

   // ---------------- driver ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      r_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         r_op1 = 8'($urandom); r_op2 = 8'($urandom); r_slave = 2'($urandom);
         next_cycle();
      end
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int idx,
                          input bit ack, input int d, input bit hold, input int rst_at,
                          output int done_off, output int err_off, output int n_done,
                          output logic [16:0] seq);
      int t0, tend;
      t0 = cyc;
      r_start = 1'b1; r_op1 = a; r_op2 = b; r_slave = 2'(idx);
      ack_en = ack; ack_delay = d;
      tend = model_start(t0, idx, a, b, ack, d);
      done_off = -1; err_off = -1; n_done = 0; seq = '0;
      forever begin
         next_cycle();
         if (cyc - t0 >= 1 && cyc - t0 <= 17) seq[cyc-t0-1] = w_mosi;
         if (w_done) begin n_done++; done_off = cyc - t0; end
         if (w_err) err_off = cyc - t0;
         if (rst_at > 0 && cyc - t0 == rst_at) begin
            // Reset together with a valid start: reset must win.
            r_rst = 1'b1; r_start = 1'b1; r_slave = 2'd0;
            model_reset(cyc);
            next_cycle();
            r_rst = 1'b0; r_start = 1'b0;
            break;
         end
         if (cyc >= tend) begin
            if (!hold) r_start = 1'b0;
            break;
         end
         if (!hold) begin
            r_start = 1'($urandom); r_op1 = 8'($urandom);
            r_op2 = 8'($urandom); r_slave = 2'($urandom);
         end
      end
   endtask

   initial begin
      int do_, eo, nd;
      logic [16:0] sq;
      logic [7:0] a, b;
      int idx, d, ra;
      bit ack, hold;

      r_rst = 1'b1; r_start = 1'b0; r_op1 = '0; r_op2 = '0; r_slave = '0;
      m_res = 8'h00;
      fill_idle(0);
      next_cycle();
      next_cycle();
      model_reset(cyc);
      chk_from = cyc + 1;
      chk_on   = 1'b1;
      next_cycle();
      r_rst = 1'b0;

      // Reset state
      chk("rst_busy",   32'(w_busy),   32'd0);
      chk("rst_nss",    32'(w_nss),    32'h7);
      chk("rst_mosi",   32'(w_mosi),   32'd0);
      chk("rst_result", 32'(w_result), 32'd0);
      chk("rst_error",  32'(w_err),    32'd0);
      idle_cycles(2);

      // 3 x 5: exact bit stream, latency and product
      run_txn(8'd3, 8'd5, 0, 1'b1, 1, 1'b0, 0, do_, eo, nd, sq);
      chk("mosi_stream_3x5", 32'(sq), 32'h00A07);
      chk("done_cycle_3x5",  32'(do_), 32'd28);
      chk("done_count_3x5",  32'(nd),  32'd1);
      chk("no_error_3x5",    32'(eo),  32'hFFFF_FFFF);
      chk("result_3x5",      32'(w_result), 32'd15);
      idle_cycles(2);

      // Truncated product
      run_txn(8'hFF, 8'h02, 1, 1'b1, 1, 1'b0, 0, do_, eo, nd, sq);
      chk("result_ffx02",     32'(w_result), 32'hFE);
      chk("done_count_ffx02", 32'(nd),       32'd1);
      chk("nss_after_ffx02",  32'(w_nss),    32'h7);
      idle_cycles(1);

      // Slave never acks: timeout 16 cycles after WAIT_ACK entry (cycle 18)
      run_txn(8'd9, 8'd9, 2, 1'b0, 0, 1'b0, 0, do_, eo, nd, sq);
      chk("timeout_cycle",  32'(eo),       32'd34);
      chk("timeout_nodone", 32'(nd),       32'd0);
      chk("timeout_result", 32'(w_result), 32'hFE);
      chk("timeout_nss",    32'(w_nss),    32'h7);
      idle_cycles(1);

      // Out-of-range slave index
      run_txn(8'd1, 8'd1, 3, 1'b1, 1, 1'b0, 0, do_, eo, nd, sq);
      chk("badidx_err_cycle", 32'(eo),     32'd1);
      chk("badidx_busy",      32'(w_busy), 32'd0);
      chk("badidx_nss",       32'(w_nss),  32'h7);
      idle_cycles(1);

      // Reset in cycle 10, then a fresh transaction
      run_txn(8'd4, 8'd4, 1, 1'b1, 1, 1'b0, 10, do_, eo, nd, sq);
      chk("abort_busy",   32'(w_busy),   32'd0);
      chk("abort_nss",    32'(w_nss),    32'h7);
      chk("abort_result", 32'(w_result), 32'd0);
      chk("abort_nodone", 32'(nd),       32'd0);
      run_txn(8'd7, 8'd9, 2, 1'b1, 1, 1'b0, 0, do_, eo, nd, sq);
      chk("after_abort_result", 32'(w_result), 32'd63);
      chk("after_abort_done",   32'(do_),      32'd28);
      idle_cycles(2);

      // Back-to-back with i_start held high
      run_txn(8'd12, 8'd11, 0, 1'b1, 1, 1'b1, 0, do_, eo, nd, sq);
      chk("b2b_first_result", 32'(w_result), 32'd132);
      run_txn(8'd12, 8'd11, 0, 1'b1, 1, 1'b0, 0, do_, eo, nd, sq);
      chk("b2b_second_done",   32'(do_),      32'd28);
      chk("b2b_second_result", 32'(w_result), 32'd132);
      idle_cycles(1);

      // Randomised traffic
      for (int it = 0; it < 40 && cyc < MAXC - 200; it++) begin
         a    = 8'($urandom);
         b    = 8'($urandom);
         idx  = $urandom_range(0, 3);
         ack  = ($urandom_range(0, 4) != 0);
         d    = $urandom_range(0, 17);
         hold = ($urandom_range(0, 3) == 0);
         ra   = (idx < NS && $urandom_range(0, 5) == 0) ? $urandom_range(1, 20) : 0;
         run_txn(a, b, idx, ack, d, hold, ra, do_, eo, nd, sq);
         if (!hold) idle_cycles($urandom_range(0, 2));
      end
      r_start = 1'b0;
      idle_cycles(3);

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
